// File: rtl/probe_capture_pkg.sv
// probe_capture_pkg
//   Shared definitions for the probe capture core: state encodings seen on
//   state_o and the pointer-width helper used to size RAM addresses.
package probe_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/probe_capture_ram.sv
// capture_ram
//   Simple dual-port sample store, DEPTH x DATA_W, one write port and one
//   synchronous read port. Contents are never reset so the array maps onto
//   block RAM.
// Ports:
//   clk      - single clock
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   re       - read enable; rd_data updates one cycle later
//   rd_addr  - read address
//   rd_data  - registered read data
module capture_ram
  import probe_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/probe_capture.sv
// probe_capture
//   On-chip capture core for an internal debug probe. Records DEPTH samples
//   around a programmable trigger, PRE_TRIG of them before it, and streams
//   the window out oldest-first over a valid/ready port.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   probe_i         - observed signal (registered once before use)
//   arm_i, abort_i  - start a capture (IDLE only) / return to IDLE
//   trig_value_i    - trigger compare value
//   trig_mask_i     - 1 = bit takes part in the compare
//   trig_edge_i     - 0 = level match, 1 = rising edge of match
//   state_o, done_o - state encoding, window ready/being read
//   rd_valid_o, rd_ready_i, rd_data_o, rd_last_o - readout stream
module probe_capture
  import probe_capture_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic              trig_edge_i,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] PRE_C    = PW'(PRE_TRIG);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_TRIG - 1);
  localparam logic [PW-1:0] POST_C   = PW'(DEPTH - PRE_TRIG - 1);
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   LAST_C   = (PW+1)'(DEPTH - 1);

  logic [2:0]        state;
  logic [DATA_W-1:0] probe_q;
  logic              match;
  logic              match_d;
  logic              trigger;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     trig_ptr;
  logic [PW-1:0]     cnt;
  logic [PW:0]       issued;
  logic              we;
  logic              re;
  logic [PW-1:0]     rd_addr;
  logic [DATA_W-1:0] ram_q;
  logic              pend;
  logic              pend_last;
  logic              pop;
  logic [1:0]        occ;
  logic              skid_valid;
  logic              skid_last;
  logic [DATA_W-1:0] skid_data;

  // Trigger compare and read-issue control. A new RAM read is issued only if
  // the word it returns will still fit in the output + skid pair after this
  // cycle's pop, which lets readout run at one word per cycle without loss.
  always_comb begin
    match   = ((probe_q ^ trig_value_i) & trig_mask_i) == '0;
    trigger = trig_edge_i ? (match && !match_d) : match;
    we      = rst_n && !abort_i &&
              (state == S_PRE || state == S_WAIT || state == S_POST);
    pop     = rd_valid_o && rd_ready_i;
    occ     = {1'b0, rd_valid_o} + {1'b0, skid_valid} + {1'b0, pend};
    re      = rst_n && !abort_i && (state == S_DONE) && (issued < DEPTH_C) &&
              (occ <= ({1'b0, pop} + 2'd1));
    rd_addr = trig_ptr - PRE_C + issued[PW-1:0];
  end

  assign state_o = state;
  assign done_o  = (state == S_DONE);

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (probe_q),
    .re      (re),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Capture FSM. cnt counts PRE writes, then holds the number of post-trigger
  // samples still to be written. The read window is addressed relative to
  // trig_ptr, so no separate read pointer is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      probe_q  <= '0;
      match_d  <= 1'b0;
      wr_ptr   <= '0;
      trig_ptr <= '0;
      cnt      <= '0;
      issued   <= '0;
    end else begin
      probe_q <= probe_i;
      match_d <= match;
      if (abort_i) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_i) begin
              state   <= S_PRE;
              wr_ptr  <= '0;
              cnt     <= '0;
              issued  <= '0;
              match_d <= 1'b0;
            end
          end
          S_PRE: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt == PRE_LAST) state <= S_WAIT;
            else                 cnt   <= cnt + 1'b1;
          end
          S_WAIT: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (trigger) begin
              trig_ptr <= wr_ptr;
              cnt      <= POST_C;
              state    <= (POST_C == '0) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            wr_ptr <= wr_ptr + 1'b1;
            cnt    <= cnt - 1'b1;
            if (cnt == PW'(1)) state <= S_DONE;
          end
          S_DONE: begin
            if (re) issued <= issued + 1'b1;
            if (pop && rd_last_o) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Readout stage: registered output word plus a one-entry skid register.
  // Returning RAM data goes to the output when it is free, otherwise to the
  // skid; the output word never changes while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_last_o  <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (abort_i) begin
      pend       <= 1'b0;
      pend_last  <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_last_o  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      pend      <= re;
      pend_last <= re && (issued == LAST_C);
      if (!rd_valid_o || rd_ready_i) begin
        if (skid_valid) begin
          rd_data_o  <= skid_data;
          rd_last_o  <= skid_last;
          rd_valid_o <= 1'b1;
          skid_valid <= pend;
          if (pend) begin
            skid_data <= ram_q;
            skid_last <= pend_last;
          end
        end else if (pend) begin
          rd_data_o  <= ram_q;
          rd_last_o  <= pend_last;
          rd_valid_o <= 1'b1;
        end else begin
          rd_valid_o <= 1'b0;
          rd_last_o  <= 1'b0;
        end
      end else if (pend) begin
        skid_data  <= ram_q;
        skid_last  <= pend_last;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_probe_capture.sv
// tb_probe_capture
//   Self-checking bench for probe_capture (DATA_W=8, DEPTH=16, PRE_TRIG=4).
//   A reference model records every probe value presented from the arm cycle
//   onward, finds the trigger sample from the trigger rules, and derives the
//   expected window and DONE latency from that history.
module tb_probe_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] probe_i;
  logic          arm_i;
  logic          abort_i;
  logic [DW-1:0] trig_value_i;
  logic [DW-1:0] trig_mask_i;
  logic          trig_edge_i;
  logic [2:0]    state_o;
  logic          done_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [DW-1:0] rd_data_o;
  logic          rd_last_o;

  int checks   = 0;
  int failures = 0;

  bit            probe_hold = 1'b0;
  bit            rec        = 1'b0;
  logic [DW-1:0] hist[$];
  logic [DW-1:0] got[$];
  bit            got_last[$];

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  probe_capture #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .PRE_TRIG (PRE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .probe_i      (probe_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_value_i (trig_value_i),
    .trig_mask_i  (trig_mask_i),
    .trig_edge_i  (trig_edge_i),
    .state_o      (state_o),
    .done_o       (done_o),
    .rd_valid_o   (rd_valid_o),
    .rd_ready_i   (rd_ready_i),
    .rd_data_o    (rd_data_o),
    .rd_last_o    (rd_last_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present arm/abort, log the probe value sampled at this
  // edge, then advance the probe counter 1 unit after the edge.
  task automatic applyStimulus(input bit arm, input bit abort);
    arm_i   = arm;
    abort_i = abort;
    if (arm) begin
      hist.delete();
      rec = 1'b1;
    end
    if (rec) hist.push_back(probe_i);
    @(posedge clk);
    #1;
    arm_i   = 1'b0;
    abort_i = 1'b0;
    if (!probe_hold) probe_i = probe_i + 8'd1;
  endtask

  function automatic bit matchOf(input logic [DW-1:0] v);
    return ((v ^ trig_value_i) & trig_mask_i) == 0;
  endfunction

  // Reference: first written sample at or after index PRE that satisfies the
  // trigger rule; -1 if the history holds none.
  function automatic int findTrigger();
    for (int k = PRE; k < hist.size(); k++) begin
      if (trig_edge_i ? (matchOf(hist[k]) && !matchOf(hist[k-1])) : matchOf(hist[k]))
        return k;
    end
    return -1;
  endfunction

  task automatic armAt(input int at);
    int guard = 0;
    while (at >= 0 && probe_i != at[7:0] && guard < 300) begin
      applyStimulus(0, 0);
      guard++;
    end
    applyStimulus(1, 0);
  endtask

  task automatic waitState(input logic [2:0] s, input int bound, output int n, output bit ok);
    n = 0;
    while (state_o != s && n < bound) begin
      applyStimulus(0, 0);
      n++;
    end
    ok = (state_o == s);
  endtask

  // Drain up to max_words words. mode 0 = always ready, 1 = toggling,
  // 2 = random. Checks output stability across every stalled cycle.
  task automatic drain(input int mode, input int max_words,
                       output int first_valid, output int span);
    bit            stalled;
    logic [DW-1:0] sd;
    bit            sl;
    int            cyc = 0;
    int            first_x = -1;
    int            last_x = -1;
    first_valid = -1;
    got.delete();
    got_last.delete();
    while (got.size() < max_words && cyc < 200) begin
      if (first_valid < 0 && rd_valid_o) first_valid = cyc;
      case (mode)
        0:       rd_ready_i = 1'b1;
        1:       rd_ready_i = (cyc % 2) == 1;
        default: rd_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (rd_valid_o && rd_ready_i) begin
        got.push_back(rd_data_o);
        got_last.push_back(rd_last_o);
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      stalled = rd_valid_o && !rd_ready_i;
      sd = rd_data_o;
      sl = rd_last_o;
      applyStimulus(0, 0);
      cyc++;
      if (stalled) checkOutput("stall_hold", {22'd0, rd_valid_o, rd_last_o, rd_data_o}, {22'd0, 1'b1, sl, sd});
    end
    span = last_x - first_x;
    rd_ready_i = 1'b1;
  endtask

  // Full capture: arm, wait for DONE, compare latency and window to the model.
  task automatic runCapture(input string tag, input logic [7:0] val, input logic [7:0] mask,
                            input bit edge_m, input int mode, input int at);
    int n, kt, fv, span;
    bit ok;
    trig_value_i = val;
    trig_mask_i  = mask;
    trig_edge_i  = edge_m;
    armAt(at);
    checkOutput($sformatf("%s:state_pre", tag), {29'd0, state_o}, 32'd1);
    waitState(3'd4, 700, n, ok);
    checkOutput($sformatf("%s:done_reached", tag), {31'd0, ok}, 32'd1);
    if (!ok) begin
      applyStimulus(0, 1);
      return;
    end
    kt = findTrigger();
    checkOutput($sformatf("%s:done_latency", tag), n, (kt < 0) ? -1 : kt + DEPTH - PRE);
    checkOutput($sformatf("%s:done_o", tag), {31'd0, done_o}, 32'd1);
    if (kt < 0) kt = PRE;
    drain(mode, DEPTH, fv, span);
    checkOutput($sformatf("%s:first_valid_le2", tag), {31'd0, (fv >= 0 && fv <= 2)}, 32'd1);
    checkOutput($sformatf("%s:word_count", tag), got.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      logic [8:0] exp_w, obs_w;
      int idx = kt - PRE + i;
      exp_w = {(i == DEPTH - 1), (idx < hist.size()) ? hist[idx] : 8'hXX};
      obs_w = (i < got.size()) ? {got_last[i], got[i]} : 9'h1FF;
      checkOutput($sformatf("%s:word%0d", tag, i), {23'd0, obs_w}, {23'd0, exp_w});
    end
    if (mode == 0) checkOutput($sformatf("%s:full_rate_span", tag), span, DEPTH - 1);
    checkOutput($sformatf("%s:idle_after", tag), {29'd0, state_o}, 32'd0);
    checkOutput($sformatf("%s:flags_after", tag), {30'd0, done_o, rd_valid_o}, 32'd0);
  endtask

  // Directed scenarios followed by randomized captures.
  initial begin
    int  n;
    bit  ok;
    int  fv, span;
    int  seen_done;

    rst_n        = 1'b0;
    probe_i      = 8'h00;
    arm_i        = 1'b0;
    abort_i      = 1'b0;
    trig_value_i = 8'h00;
    trig_mask_i  = 8'h00;
    trig_edge_i  = 1'b0;
    rd_ready_i   = 1'b1;

    repeat (3) applyStimulus(0, 0);
    checkOutput("reset:state", {29'd0, state_o}, 32'd0);
    checkOutput("reset:done", {31'd0, done_o}, 32'd0);
    checkOutput("reset:valid", {31'd0, rd_valid_o}, 32'd0);
    checkOutput("reset:data", {24'd0, rd_data_o}, 32'd0);
    checkOutput("reset:last", {31'd0, rd_last_o}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0);

    $display("[TB] level trigger");
    runCapture("level", 8'h20, 8'hFF, 1'b0, 0, 8'h05);
    checkOutput("level:first_word", {24'd0, got[0]}, 32'h1C);
    checkOutput("level:trig_word", {24'd0, got[PRE]}, 32'h20);
    checkOutput("level:last_word", {24'd0, got[DEPTH-1]}, 32'h2B);

    $display("[TB] trigger inside PRE is skipped");
    runCapture("in_pre", 8'h20, 8'hFF, 1'b0, 0, 8'h1E);
    checkOutput("in_pre:first_word", {24'd0, got[0]}, 32'h1C);
    checkOutput("in_pre:last_word", {24'd0, got[DEPTH-1]}, 32'h2B);

    $display("[TB] edge vs level on a held probe");
    probe_hold   = 1'b1;
    probe_i      = 8'hAA;
    trig_value_i = 8'hAA;
    trig_mask_i  = 8'hFF;
    trig_edge_i  = 1'b1;
    applyStimulus(1, 0);
    seen_done = 0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(0, 0);
      if (state_o == 3'd4) seen_done++;
    end
    checkOutput("edge_hold:never_done", seen_done, 0);
    applyStimulus(0, 1);
    checkOutput("edge_hold:abort_idle", {29'd0, state_o}, 32'd0);
    runCapture("level_hold", 8'hAA, 8'hFF, 1'b0, 0, -1);
    checkOutput("level_hold:word7", {24'd0, got[7]}, 32'hAA);
    probe_hold = 1'b0;

    $display("[TB] backpressure");
    runCapture("bp", 8'h20, 8'hFF, 1'b0, 1, 8'h05);

    $display("[TB] arm and abort together");
    applyStimulus(1, 1);
    checkOutput("arm_abort:state", {29'd0, state_o}, 32'd0);

    $display("[TB] abort mid-POST");
    trig_value_i = 8'h20;
    trig_mask_i  = 8'hFF;
    trig_edge_i  = 1'b0;
    armAt(8'h05);
    waitState(3'd3, 400, n, ok);
    checkOutput("abort:post_reached", {31'd0, ok}, 32'd1);
    repeat (2) applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("abort:state", {29'd0, state_o}, 32'd0);
    checkOutput("abort:flags", {30'd0, done_o, rd_valid_o}, 32'd0);
    runCapture("rearm", 8'h20, 8'hFF, 1'b0, 0, 8'h05);

    $display("[TB] reset mid-readout");
    armAt(8'h05);
    waitState(3'd4, 400, n, ok);
    checkOutput("rst_mid:done_reached", {31'd0, ok}, 32'd1);
    drain(0, 5, fv, span);
    checkOutput("rst_mid:five_words", got.size(), 5);
    rst_n = 1'b0;
    applyStimulus(0, 0);
    checkOutput("rst_mid:outputs", {19'd0, state_o, done_o, rd_valid_o, rd_last_o, rd_data_o}, 32'd0);
    rst_n = 1'b1;
    runCapture("after_rst", 8'h20, 8'hFF, 1'b0, 0, 8'h05);

    $display("[TB] randomized captures");
    for (int r = 0; r < 6; r++) begin
      logic [7:0] v, m;
      bit         e;
      v = 8'($urandom);
      e = 1'($urandom_range(0, 1));
      m = 8'($urandom) | (8'h01 << $urandom_range(0, 7));
      runCapture($sformatf("rand%0d", r), v, m, e, 2, $urandom_range(0, 255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/probe_capture.md
# probe_capture

Parametrised on-chip capture core for internal debug probes, such as the 32-bit PWM setpoint bus. It records a window of `DEPTH` samples around a programmable trigger into block RAM, with `PRE_TRIG` of those samples taken before the trigger. It then streams the window out oldest-first over a valid/ready interface, so a UART or register readout path can drain it without a vendor JTAG analyzer.

## Interface
- `DATA_W`, 32: probe width in bits.
- `DEPTH`, 256: capture depth in samples; power of two, at least 4.
- `PRE_TRIG`, 64: samples kept before the trigger; 1 ≤ `PRE_TRIG` ≤ `DEPTH`-1.
- `clk`  in  1  single clock for capture and readout.
- `rst_n`  in  1  synchronous reset, active-low.
- `probe_i`  in  `DATA_W`  signal under observation.
- `arm_i`  in  1  one-cycle pulse; starts a capture; honoured only in IDLE.
- `abort_i`  in  1  one-cycle pulse; returns to IDLE from any state.
- `trig_value_i`  in  `DATA_W`  trigger compare value.
- `trig_mask_i`  in  `DATA_W`  1 = bit participates in the compare.
- `trig_edge_i`  in  1  0 = level match, 1 = rising edge of match.
- `state_o`  out  3  current state encoding.
- `done_o`  out  1  high while the window is ready or being read.
- `rd_valid_o`  out  1  readout word valid.
- `rd_ready_i`  in  1  readout consumer ready.
- `rd_data_o`  out  `DATA_W`  readout sample.
- `rd_last_o`  out  1  marks the final (`DEPTH`-th) word.

## Operation
- `probe_i` is registered once into `probe_q`. All writes and trigger evaluation use `probe_q`.
- match = ((`probe_q` ^ `trig_value_i`) & `trig_mask_i`) == 0.
- Trigger rule in edge mode: match && !match_d, where match_d is the previous cycle's match and is cleared on arm.
- Trigger rule in level mode: match. A mask of 0 in level mode therefore triggers on the first eligible sample.
- IDLE → PRE on `arm_i`. On entry `wr_ptr` = 0 and the counter = 0.
- PRE: writes one sample per cycle. After `PRE_TRIG` writes, the state becomes WAIT. Triggers are ignored in PRE.
- WAIT: writes every cycle; `wr_ptr` wraps modulo `DEPTH`. On trigger:
  - `trig_ptr` = `wr_ptr`; the trigger sample is written.
  - State becomes POST with remaining = `DEPTH`-`PRE_TRIG`-1.
  - If remaining = 0, state goes directly to DONE.
- POST: writes every cycle and decrements remaining. When the last sample is written, state becomes DONE.
- DONE: read pointer starts at (`trig_ptr` - `PRE_TRIG`) mod `DEPTH`. The core streams exactly `DEPTH` words in order, oldest first. The trigger sample is word index `PRE_TRIG`.
- After the handshake on `rd_last_o`, the state returns to IDLE.
- `abort_i` wins over every other input. Next cycle: state IDLE, `done_o` = 0, `rd_valid_o` = 0. RAM contents are left as-is.
- `arm_i` outside IDLE is ignored. `arm_i` and `abort_i` in the same cycle: abort wins, arm is discarded.
- `trig_*` inputs are sampled live. Software holds them stable from arm to trigger.

## Timing
- Reset (`rst_n` low at a `clk` edge): state IDLE.
- Reset values: `state_o` = 0, `done_o` = 0, `rd_valid_o` = 0, `rd_data_o` = 0, `rd_last_o` = 0, all pointers and counters 0, `probe_q` = 0, match_d = 0.
- Reset mid-capture or mid-readout has the same effect.
- Capture latency: `probe_i` at cycle t is written at cycle t+1. A trigger is recognised in the cycle its sample is written.
- RAM read is synchronous (1 cycle). The first `rd_valid_o` rises no later than 2 cycles after entering DONE.
- Handshake: a word transfers on `rd_valid_o` && `rd_ready_i`.
- While `rd_valid_o` && !`rd_ready_i`, `rd_data_o` and `rd_last_o` hold stable. Use a one-entry prefetch/skid register.
- Full-rate readout sustains 1 word/cycle with `rd_ready_i` held high.
- `done_o` rises on the DONE entry cycle and falls the cycle after the last handshake.
- State encoding: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4.

## Structure
- `probe_capture_pkg` holds:
  - the state enum;
  - the pointer width function clog2(`DEPTH`);
  - the state encodings used by `state_o`.
- Sub-module `capture_ram` is a simple dual-port RAM, `DEPTH` x `DATA_W`, with one write port, one synchronous read port and no reset on contents. Write it so it infers BSRAM.
- All control logic lives in the top: FSM, counters, trigger compare, prefetch.

## Test plan
Common setup: `DATA_W`=8, `DEPTH`=16, `PRE_TRIG`=4, `probe_i` = 8-bit free-running counter, `rd_ready_i`=1 unless stated.
- Level trigger: value 0x20, mask 0xFF, arm when the probe is 0x05 → readout 0x1C..0x2B in order, 0x20 at index 4, `rd_last_o` only on 0x2B, then IDLE.
- Trigger inside PRE: arm when the probe is 0x1E, value 0x20 → trigger skipped. The capture fires on the next 0x20 (256 cycles later) → readout 0x1C..0x2B.
- Edge vs level: probe held at 0xAA, value 0xAA, mask 0xFF → with `trig_edge_i`=1 it never reaches DONE in 1000 cycles; with `trig_edge_i`=0, DONE follows 16 writes after arm, and all 16 words read 0xAA.
- Backpressure: rerun the first scenario with `rd_ready_i` toggling every cycle → identical 16-word sequence, no duplicates or drops, data stable while stalled.
- Abort mid-POST: pulse `abort_i` → next cycle `state_o`=0, `done_o`=0. Re-arming then gives a correct window.
- Reset mid-readout: drop `rst_n` after the 5th word → all outputs at reset values next cycle, and `arm_i` works afterwards.
